// File: rtl/cla_pipe_adder.sv
// Pipelined two-level carry-lookahead adder/subtractor with a valid/ready handshake on both sides.
// Optional saturation on signed overflow is enabled by defining CLA_SAT_EN.
module cla_pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NG  = WIDTH / 4;
  localparam int GPS = NG / STAGES;
  localparam int SW  = 4 * GPS;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Global stall: every stage moves together whenever the output slot can drain.
  assign in_ready = !out_valid || out_ready;
  assign advance  = in_ready;
  assign b_eff    = sub ? ~b : b;
  assign c0       = sub | cin;

  function automatic logic [1:0] grp_gp(input logic [3:0] p, input logic [3:0] g);
    logic gg;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {gg, &p};
  endfunction

  function automatic logic [3:0] grp_sum(input logic [3:0] p, input logic [2:0] g, input logic ci);
    logic [3:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return p ^ c;
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int UW = WIDTH - k * SW;

    logic [UW-1:0]         a_in;
    logic [UW-1:0]         b_in;
    logic                  c_in;
    logic                  v_in;
    logic [SW-1:0]         p_s;
    logic [SW-1:0]         g_s;
    logic [SW-1:0]         s_bits;
    logic [GPS-1:0]        gm;
    logic [GPS-1:0]        pm;
    logic [GPS:0]          gc;
    logic [(k+1)*SW-1:0]   s_lo;
    logic [(k+1)*SW-1:0]   s_d;
    logic [(k+1)*SW-1:0]   s_q;
    logic                  v_q;
    logic                  c_q;

    if (k == 0) begin : g_src
      assign a_in = a;
      assign b_in = b_eff;
      assign c_in = c0;
      assign v_in = in_valid;
      assign s_lo = s_bits;
    end else begin : g_src
      assign a_in = g_stage[k-1].g_fwd.a_q;
      assign b_in = g_stage[k-1].g_fwd.b_q;
      assign c_in = g_stage[k-1].c_q;
      assign v_in = g_stage[k-1].v_q;
      assign s_lo = {s_bits, g_stage[k-1].s_q};
    end

    assign p_s = a_in[SW-1:0] ^ b_in[SW-1:0];
    assign g_s = a_in[SW-1:0] & b_in[SW-1:0];

    // Group carries are flat sum-of-products over this stage's Gm/Pm, no ripple between groups.
    always_comb begin
      logic cc;
      logic pp;
      gc     = '0;
      gm     = '0;
      pm     = '0;
      s_bits = '0;
      cc     = 1'b0;
      pp     = 1'b0;
      for (int j = 0; j < GPS; j++) begin
        {gm[j], pm[j]} = grp_gp(p_s[4*j +: 4], g_s[4*j +: 4]);
      end
      gc[0] = c_in;
      for (int j = 0; j < GPS; j++) begin
        cc = gm[j];
        pp = pm[j];
        for (int i = j - 1; i >= 0; i--) begin
          cc = cc | (pp & gm[i]);
          pp = pp & pm[i];
        end
        gc[j+1] = cc | (pp & c_in);
      end
      for (int j = 0; j < GPS; j++) begin
        s_bits[4*j +: 4] = grp_sum(p_s[4*j +: 4], g_s[4*j +: 3], gc[j]);
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic msb_cin;
      logic ovf_d;
      logic o_q;

      // Recover the carry into the MSB from its sum bit rather than exposing internal carries.
      assign msb_cin = s_bits[SW-1] ^ p_s[SW-1];
      assign ovf_d   = msb_cin ^ gc[GPS];

`ifdef CLA_SAT_EN
      always_comb begin
        s_d = s_lo;
        if (ovf_d) begin
          s_d = a_in[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
      end
`else
      assign s_d = s_lo;
`endif

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          o_q <= 1'b0;
        end else if (advance) begin
          o_q <= ovf_d;
        end
      end
    end else begin : g_fwd
      logic [UW-SW-1:0] a_q;
      logic [UW-SW-1:0] b_q;

      assign s_d = s_lo;

      always_ff @(posedge clk) begin
        if (advance) begin
          a_q <= a_in[UW-1:SW];
          b_q <= b_in[UW-1:SW];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= v_in;
        c_q <= gc[GPS];
        s_q <= s_d;
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_last.o_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed self-checking bench for cla_pipe_adder: 16-bit/2-stage and 8-bit/1-stage instances.
// Expected sums follow the saturating variant when CLA_SAT_EN is defined.
module tb_cla_pipe_adder;
`ifdef CLA_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid16, in_ready16, cin16, sub16, out_valid16, out_ready16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;
  logic        in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(16), .STAGES(2)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .sub(sub16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  cla_pipe_adder #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sb;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec16_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one beat on the 16-bit instance and samples it one and two cycles later.
  task automatic run16(input vec16_t v, output logic v1, output logic v2,
                       output logic [15:0] s, output logic c, output logic o);
    a16 = v.a; b16 = v.b; cin16 = v.ci; sub16 = v.sb;
    out_ready16 = 1'b1; in_valid16 = 1'b1;
    tick();
    in_valid16 = 1'b0;
    v1 = out_valid16;
    tick();
    v2 = out_valid16; s = sum16; c = cout16; o = ovf16;
  endtask

  task automatic check_vec16(input string nm, input vec16_t v);
    logic v1, v2, c, o;
    logic [15:0] s;
    run16(v, v1, v2, s, c, o);
    n_cmp++;
    if (v1 !== 1'b0 || v2 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s latency: out_valid after 1/2 cycles = %b/%b, required 0/1", nm, v1, v2);
    end
    n_cmp++;
    if (s !== v.s) begin
      n_fail++;
      $display("FAIL %s sum: got %h, required %h", nm, s, v.s);
    end
    n_cmp++;
    if (c !== v.c || o !== v.o) begin
      n_fail++;
      $display("FAIL %s cout/ovf: got %b/%b, required %b/%b", nm, c, o, v.c, v.o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; out_ready16 = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if (out_valid16 !== 1'b0 || sum16 !== 16'h0 || cout16 !== 1'b0 || ovf16 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset16_outputs: valid/sum/cout/ovf = %b/%h/%b/%b, required 0/0000/0/0",
               out_valid16, sum16, cout16, ovf16);
    end
    n_cmp++;
    if (in_ready16 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset16_in_ready: got %b, required 1", in_ready16);
    end
    n_cmp++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || sum8 !== 8'h0) begin
      n_fail++;
      $display("FAIL reset8: valid/in_ready/sum = %b/%b/%h, required 0/1/00",
               out_valid8, in_ready8, sum8);
    end
  endtask

  task automatic test_add();
    vec16_t t[5];
    t[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    t[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1};
    t[2] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    t[3] = '{16'h1000, 16'h0234, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0};
    t[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) check_vec16($sformatf("add%0d", i), t[i]);
  endtask

  task automatic test_sub();
    vec16_t t[4];
    t[0] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    t[1] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    t[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1};
    t[3] = '{16'h0100, 16'h0001, 1'b0, 1'b1, 16'h00FF, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) check_vec16($sformatf("sub%0d", i), t[i]);
  endtask

  task automatic test_w8();
    logic [7:0] ta[4], tb[4], ts[4];
    logic       tsub[4], tc[4], to[4];
    ta = '{8'h80, 8'h7F, 8'h10, 8'hFF};
    tb = '{8'h80, 8'h01, 8'h20, 8'h01};
    tsub = '{1'b0, 1'b0, 1'b1, 1'b0};
    ts = '{SAT ? 8'h80 : 8'h00, SAT ? 8'h7F : 8'h80, 8'hF0, 8'h00};
    tc = '{1'b1, 1'b0, 1'b0, 1'b1};
    to = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      a8 = ta[i]; b8 = tb[i]; sub8 = tsub[i]; cin8 = 1'b0;
      out_ready8 = 1'b1; in_valid8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
      n_cmp++;
      if (out_valid8 !== 1'b1 || sum8 !== ts[i] || cout8 !== tc[i] || ovf8 !== to[i]) begin
        n_fail++;
        $display("FAIL w8_%0d: valid/sum/cout/ovf = %b/%h/%b/%b, required 1/%h/%b/%b",
                 i, out_valid8, sum8, cout8, ovf8, ts[i], tc[i], to[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_s[4];
    int sent, got, cyc, stall;
    bit seen;
    exp_s = '{16'h0002, 16'h0004, 16'h0006, 16'h0008};
    sent = 0; got = 0; cyc = 0; stall = 0; seen = 1'b0;
    sub16 = 1'b0; cin16 = 1'b0;
    while (got < 4 && cyc < 40) begin
      if (out_valid16 && !seen) begin
        seen = 1'b1;
        stall = 3;
      end
      out_ready16 = (stall == 0);
      in_valid16 = (sent < 4);
      a16 = 16'(sent + 1);
      b16 = 16'(sent + 1);
      #1;
      if (stall > 0) begin
        n_cmp++;
        if (out_valid16 !== 1'b1 || sum16 !== 16'h0002 || in_ready16 !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_stall_hold: valid/sum/in_ready = %b/%h/%b, required 1/0002/0",
                   out_valid16, sum16, in_ready16);
        end
        stall--;
      end
      if (in_valid16 && in_ready16) sent++;
      if (out_valid16 && out_ready16) begin
        n_cmp++;
        if (sum16 !== exp_s[got]) begin
          n_fail++;
          $display("FAIL b2b_order%0d: got %h, required %h", got, sum16, exp_s[got]);
        end
        got++;
      end
      tick();
      cyc++;
    end
    in_valid16 = 1'b0;
    out_ready16 = 1'b1;
    n_cmp++;
    if (got != 4) begin
      n_fail++;
      $display("FAIL b2b_count: received %0d results, required 4", got);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (out_valid16 !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_no_dup%0d: out_valid %b sum %h, required out_valid 0", i, out_valid16, sum16);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    bit leaked;
    out_ready16 = 1'b0; sub16 = 1'b0; cin16 = 1'b0;
    a16 = 16'h0011; b16 = 16'h0022; in_valid16 = 1'b1;
    #1;
    n_cmp++;
    if (in_ready16 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_accept1: in_ready %b, required 1", in_ready16);
    end
    tick();
    a16 = 16'h0033; b16 = 16'h0044;
    #1;
    n_cmp++;
    if (in_ready16 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_accept2: in_ready %b, required 1", in_ready16);
    end
    tick();
    in_valid16 = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_state: out_valid/in_ready = %b/%b, required 0/1", out_valid16, in_ready16);
    end
    out_ready16 = 1'b1;
    leaked = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid16 !== 1'b0) leaked = 1'b1;
    end
    n_cmp++;
    if (leaked) begin
      n_fail++;
      $display("FAIL mid_reset_discard: a discarded beat reached the output (out_valid seen 1), required never");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_w8();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups.
- Uses a two-level scheme: per-group generate/propagate feeds a group-level carry lookahead.
- Carry chain is split across STAGES register stages, with a valid/ready handshake on both sides.
- Sits in the datapath wherever a WIDTH-bit add/sub must close timing at high clock rates; it replaces flat single-cycle CLA chains.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of 4, range 4..64
STAGES, 2, pipeline depth; must divide WIDTH/4 evenly, range 1..WIDTH/4

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in; used only when sub=0
sub  input  1  1 = A - B, 0 = A + B + cin
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
cout  output  1  carry-out; for sub, 1 = no borrow
ovf  output  1  signed (two's complement) overflow

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
  - Ports are clk and rst_n; rst_n sampled on the rising edge of clk.
- Reset values:
  - All stage valid bits, out_valid, sum, cout and ovf are 0.
  - in_ready is 1 once out_valid is 0.
  - Internal operand/partial-sum registers need not be reset.
- Operand conditioning at acceptance:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? 1 : cin.
- Group math:
  - GPS = WIDTH/(4*STAGES) groups per stage.
  - Per bit: p = a^b_eff, g = a&b_eff.
  - Per group: carries from the 4-bit lookahead equations, plus group Gm/Pm.
  - Within a stage, group carries come from lookahead over that stage's Gm/Pm, not ripple.
- Stage k:
  - Computes sum bits for groups k*GPS .. (k+1)*GPS-1 from the registered carry entering the stage.
  - Registers those sum bits, the outgoing carry, and the untouched upper operand bits.
  - Lower sum bits already computed are carried forward unchanged.
- Final stage outputs:
  - sum = full WIDTH result.
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB.
- Latency: exactly STAGES cycles from accepted beat (in_valid & in_ready) to out_valid, with no stall.
- Throughput: one beat per cycle while out_ready stays high.
- Handshake:
  - in_ready = !out_valid | out_ready, combinational; no dependence on in_valid.
  - The whole pipeline advances only when in_ready=1 (global stall). Bubbles are not collapsed.
  - A stage's valid bit loads the previous stage's valid bit on advance; stage 0 loads in_valid.
  - While out_valid=1 and out_ready=0: sum, cout, ovf, out_valid hold stable and all stages hold.
  - Beat transfer on the output occurs when out_valid & out_ready.
  - Results are emitted in acceptance order; no drop or duplication.
- Boundary cases:
  - Full wrap: a=all-ones, b=1 gives sum=0, cout=1.
  - Subtract with a==b gives sum=0, cout=1, ovf=0.
  - in_valid=0 while advancing inserts a bubble (valid bit 0); downstream sees out_valid=0 for that slot.
  - Simultaneous output consume and new input in the same cycle is allowed and is the normal full-rate case.
- Reset mid-operation: all in-flight beats are discarded. The cycle after reset shows out_valid=0 and in_ready=1; none of the discarded beats is ever emitted.

Optional Feature:
- Macro: CLA_SAT_EN.
- Defined: when ovf=1, sum saturates.
  - Positive overflow (operand signs +, result sign -) gives 0 followed by WIDTH-1 ones.
  - Negative overflow gives 1 followed by WIDTH-1 zeros.
  - ovf is still reported as 1; cout is unaffected.
  - Saturation is applied in the final stage; latency is unchanged.
- Not defined: sum is the wrapped modular result; no saturation logic is present.

Test Plan:
- WIDTH=16, STAGES=2; a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 -> 2 cycles later sum=0x0000, cout=1, ovf=0.
- a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1; with CLA_SAT_EN, sum=0x7FFF, ovf=1.
- a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0; a=b=0x1234, sub=1 -> sum=0x0000, cout=1.
- Four back-to-back beats (1+1, 2+2, 3+3, 4+4); out_ready=0 for 3 cycles after the first out_valid -> first result 0x0002 held stable, in_ready=0 during stall, then 0x0004, 0x0006, 0x0008 in order with no loss.
- Accept two beats, assert rst_n=0 for one cycle -> next cycle out_valid=0, in_ready=1; neither in-flight result ever appears.
- WIDTH=8, STAGES=1; a=0x80, b=0x80 -> 1-cycle latency, sum=0x00, cout=1, ovf=1; with CLA_SAT_EN, sum=0x80.
